// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, ALU opcodes and sequencing state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int SIZE_DEF = 6;
  localparam int IMMW_DEF = 4;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_SLL = 3'b100;
  localparam logic [2:0] c_OP_SRL = 3'b101;
  localparam logic [2:0] c_OP_SRA = 3'b110;
  localparam logic [2:0] c_OP_RL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Two requester request/response channels of the ALU arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int IMMW = IMMW_DEF
);

  logic            req0_valid, req0_ready;
  logic [SIZE-1:0] req0_a, req0_b;
  logic [2:0]      req0_op;
  logic [IMMW-1:0] req0_imm;
  logic            resp0_valid, resp0_ready;
  logic [SIZE-1:0] resp0_data;

  logic            req1_valid, req1_ready;
  logic [SIZE-1:0] req1_a, req1_b;
  logic [2:0]      req1_op;
  logic [IMMW-1:0] req1_imm;
  logic            resp1_valid, resp1_ready;
  logic [SIZE-1:0] resp1_data;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_imm, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_imm, resp1_ready,
    output req0_ready, resp0_valid, resp0_data,
    output req1_ready, resp1_valid, resp1_data
  );

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_imm, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_imm, resp1_ready,
    input  req0_ready, resp0_valid, resp0_data,
    input  req1_ready, resp1_valid, resp1_data
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pref,
  input  logic       update,
  output logic [1:0] gnt_onehot,
  output logic       pref_next
);

  // Single requester wins outright; on contention the preferred one wins.
  // On update the preference moves to the requester that did not win.
  always_comb begin
    gnt_onehot = valid;
    pref_next  = pref;
    if (valid == 2'b11) begin
      gnt_onehot = pref ? 2'b10 : 2'b01;
    end
    if (update) begin
      pref_next = gnt_onehot[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one external combinational ALU
//               between two valid/ready requesters
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int IMMW = IMMW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic [IMMW-1:0] alu_imm,
  input  logic [SIZE-1:0] alu_out
);

  state_e          r_state, w_state_next;
  logic            r_pref, w_pref_next;
  logic            r_gnt;
  logic [SIZE-1:0] r_result;
  logic [1:0]      w_valid, w_gnt_onehot;
  logic            w_accept, w_in_resp, w_resp_done;

  // Requests are only visible to the picker while idle, so both readys are
  // low in EXEC and RESP without extra gating.
  assign w_valid = (r_state == IDLE) ? {bus.req1_valid, bus.req0_valid} : 2'b00;

  // The preference flips at grant time rather than at response completion;
  // it is only consulted in IDLE and reset clears it, so the two are
  // indistinguishable from outside.
  rr_arb2 u_rr_arb2 (
    .valid      (w_valid),
    .pref       (r_pref),
    .update     (w_accept),
    .gnt_onehot (w_gnt_onehot),
    .pref_next  (w_pref_next)
  );

  assign bus.req0_ready = w_gnt_onehot[0];
  assign bus.req1_ready = w_gnt_onehot[1];
  assign w_accept       = |w_gnt_onehot;

  assign w_in_resp       = (r_state == RESP);
  assign bus.resp0_valid = w_in_resp && !r_gnt;
  assign bus.resp1_valid = w_in_resp &&  r_gnt;
  assign bus.resp0_data  = bus.resp0_valid ? r_result : '0;
  assign bus.resp1_data  = bus.resp1_valid ? r_result : '0;
  assign w_resp_done     = w_in_resp && (r_gnt ? bus.resp1_ready : bus.resp0_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: accept -> one EXEC cycle -> hold in RESP until taken
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)    w_state_next = EXEC;
      EXEC:                     w_state_next = RESP;
      RESP:    if (w_resp_done) w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pref   <= 1'b0;
      r_gnt    <= 1'b0;
      r_result <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= 3'b000;
      alu_imm  <= '0;
    end else begin
      r_pref <= w_pref_next;
      if (w_accept) begin
        r_gnt   <= w_gnt_onehot[1];
        alu_a   <= w_gnt_onehot[1] ? bus.req1_a   : bus.req0_a;
        alu_b   <= w_gnt_onehot[1] ? bus.req1_b   : bus.req0_b;
        alu_op  <= w_gnt_onehot[1] ? bus.req1_op  : bus.req0_op;
        alu_imm <= w_gnt_onehot[1] ? bus.req1_imm : bus.req0_imm;
      end
      if (r_state == EXEC) begin
        r_result <= alu_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic       clk, rst;
  logic [5:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic [3:0] alu_imm;
  int         checks = 0;
  int         errors = 0;

  alu_arbiter_if #(.SIZE(6), .IMMW(4)) bus ();

  alu_arbiter #(.SIZE(6), .IMMW(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_imm(alu_imm), .alu_out(alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the existing ALU, from its opcode table
  function automatic logic [5:0] alu_model(logic [5:0] a, logic [5:0] b, logic [2:0] op, logic [3:0] imm);
    logic signed [5:0] sa;
    logic [5:0] r;
    sa = a;
    r  = '0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a << imm;
      3'b101: r = a >> imm;
      3'b110: r = sa >>> imm;
      default: begin
        r = a;
        for (int i = 0; i < imm % 6; i++) r = {r[4:0], r[5]};
      end
    endcase
    return r;
  endfunction

  // Stand-in for the external ALU
  always_comb alu_out = alu_model(alu_a, alu_b, alu_op, alu_imm);

  // Requester protocol: a valid may not drop before it has been accepted
  logic p0v, p0r, p1v, p1r;
  always @(posedge clk) begin
    if (rst) begin
      p0v <= 1'b0; p0r <= 1'b0; p1v <= 1'b0; p1r <= 1'b0;
    end else begin
      assert (!(p0v && !p0r && !bus.req0_valid)) else $error("protocol: req0_valid dropped before ready");
      assert (!(p1v && !p1r && !bus.req1_valid)) else $error("protocol: req1_valid dropped before ready");
      p0v <= bus.req0_valid; p0r <= bus.req0_ready;
      p1v <= bus.req1_valid; p1r <= bus.req1_ready;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req0(logic [5:0] a, logic [5:0] b, logic [2:0] op, logic [3:0] imm);
    bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_imm = imm;
  endtask

  task automatic set_req1(logic [5:0] a, logic [5:0] b, logic [2:0] op, logic [3:0] imm);
    bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_imm = imm;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_data, bus.resp1_data,
         alu_a, alu_b, alu_op, alu_imm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b%b rvalid=%b%b d0=%h d1=%h a=%h b=%h op=%b imm=%h, want all 0",
               bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_data,
               bus.resp1_data, alu_a, alu_b, alu_op, alu_imm);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req0(6'd20, 6'd15, 3'b000, 4'd0);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b want 01", {bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, bus.resp0_valid} !== {6'd20, 6'd15, 1'b0}) begin
      errors++; $display("FAIL single_exec: a=%0d b=%0d rv0=%b want 20 15 0", alu_a, alu_b, bus.resp0_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp0_valid, bus.resp0_data, bus.resp1_valid} !== {1'b1, 6'd35, 1'b0}) begin
      errors++; $display("FAIL single_resp: rv0=%b d0=%0d rv1=%b want 1 35 0", bus.resp0_valid, bus.resp0_data, bus.resp1_valid);
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_release: rv0=%b want 0", bus.resp0_valid);
    end
  endtask

  task automatic test_both();
    apply_reset();
    @(negedge clk);
    set_req0(6'd5, 6'd9, 3'b001, 4'd0);
    set_req1(6'h3C, 6'h0F, 3'b010, 4'd0);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL both_first: got %b want 01", {bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp0_valid, bus.resp0_data, bus.resp1_valid} !== {1'b1, 6'h3C, 1'b0}) begin
      errors++; $display("FAIL both_resp0: rv0=%b d0=%h rv1=%b want 1 3c 0", bus.resp0_valid, bus.resp0_data, bus.resp1_valid);
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      errors++; $display("FAIL both_second: got %b want 10", {bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp1_valid, bus.resp1_data, bus.resp0_valid} !== {1'b1, 6'h0C, 1'b0}) begin
      errors++; $display("FAIL both_resp1: rv1=%b d1=%h rv0=%b want 1 0c 0", bus.resp1_valid, bus.resp1_data, bus.resp0_valid);
    end
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
  endtask

  task automatic test_contention();
    int grants[$];
    int times[$];
    apply_reset();
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    @(negedge clk);
    set_req0(6'd1, 6'd2, 3'b000, 4'd0);
    set_req1(6'd3, 6'd4, 3'b011, 4'd0);
    for (int c = 0; c < 60 && grants.size() < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (times.size() > 0 && times[times.size()-1] == c - 1) begin
        if (grants[grants.size()-1] == 0) set_req0(6'($urandom), 6'($urandom), 3'b000, 4'd0);
        else                              set_req1(6'($urandom), 6'($urandom), 3'b011, 4'd0);
      end
      #1;
      if (bus.req0_ready) begin grants.push_back(0); times.push_back(c); end
      else if (bus.req1_ready) begin grants.push_back(1); times.push_back(c); end
    end
    checks++;
    if (grants.size() != 8) begin
      errors++; $display("FAIL contention_count: got %0d grants want 8", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != i % 2) begin
        errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, grants[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (times[i] - times[i-1] != 3) begin
          errors++; $display("FAIL contention_spacing[%0d]: got %0d want 3", i, times[i] - times[i-1]);
        end
      end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    @(negedge clk);
    set_req1(6'b100001, 6'd0, 3'b111, 4'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    set_req0(6'd7, 6'd8, 3'b000, 4'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.resp1_valid, bus.resp1_data, bus.req0_ready, bus.req1_ready, bus.resp0_valid} !==
          {1'b1, 6'b000011, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: rv1=%b d1=%b rdy=%b%b rv0=%b want 1 000011 00 0", i, bus.resp1_valid,
                 bus.resp1_data, bus.req0_ready, bus.req1_ready, bus.resp0_valid);
      end
    end
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
    #1;
    checks++;
    if ({bus.resp1_valid, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release: rv1=%b rdy0=%b want 0 1", bus.resp1_valid, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp0_valid, bus.resp0_data} !== {1'b1, 6'd15}) begin
      errors++; $display("FAIL hold_next: rv0=%b d0=%0d want 1 15", bus.resp0_valid, bus.resp0_data);
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    set_req0(6'b100100, 6'd0, 3'b110, 4'd2);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_op, alu_imm} !== {6'b100100, 3'b110, 4'd2}) begin
      errors++; $display("FAIL midrst_exec: a=%b op=%b imm=%0d want 100100 110 2", alu_a, alu_op, alu_imm);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_data, bus.resp1_data,
         alu_a, alu_b, alu_op, alu_imm} !== '0) begin
      errors++; $display("FAIL midrst_clear: a=%b op=%b imm=%0d rv=%b%b want all 0", alu_a, alu_op, alu_imm,
                         bus.resp0_valid, bus.resp1_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin
      errors++; $display("FAIL midrst_noresp: rv=%b%b want 00", bus.resp0_valid, bus.resp1_valid);
    end
    @(negedge clk);
    set_req0(6'b100100, 6'd0, 3'b110, 4'd2);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp0_valid, bus.resp0_data} !== {1'b1, 6'b111001}) begin
      errors++; $display("FAIL midrst_repeat: rv0=%b d0=%b want 1 111001", bus.resp0_valid, bus.resp0_data);
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
  endtask

  task automatic test_only_req1();
    apply_reset();
    @(negedge clk);
    set_req1(6'b000011, 6'd0, 3'b100, 4'd3);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      errors++; $display("FAIL only1_ready: got %b want 10", {bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.resp1_valid, bus.resp1_data} !== {1'b1, 6'b011000}) begin
      errors++; $display("FAIL only1_resp: rv1=%b d1=%b want 1 011000", bus.resp1_valid, bus.resp1_data);
    end
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
    set_req0(6'd1, 6'd1, 3'b000, 4'd0);
    set_req1(6'd2, 6'd2, 3'b000, 4'd0);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL only1_pref: got %b want 01", {bus.req1_ready, bus.req0_ready});
    end
  endtask

  task automatic test_random(input int ncyc);
    bit         v[2];
    logic [5:0] ra[2], rb[2];
    logic [2:0] rop[2];
    logic [3:0] rimm[2];
    bit         busy, er0, er1, rv;
    int         age, mg, pref;
    logic [5:0] ma, mb, mres;
    logic [2:0] mop;
    logic [3:0] mimm;
    apply_reset();
    v[0] = 0; v[1] = 0; busy = 0; age = 0; mg = 0; pref = 0;
    ma = '0; mb = '0; mop = '0; mimm = '0; mres = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && $urandom_range(0, 1) == 1) begin
          v[n]    = 1;
          ra[n]   = 6'($urandom);
          rb[n]   = 6'($urandom);
          rop[n]  = 3'($urandom);
          rimm[n] = (rop[n] == 3'b111) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
        end
      end
      bus.req0_valid = v[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0]; bus.req0_op = rop[0]; bus.req0_imm = rimm[0];
      bus.req1_valid = v[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1]; bus.req1_op = rop[1]; bus.req1_imm = rimm[1];
      bus.resp0_ready = ($urandom_range(0, 2) != 0);
      bus.resp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      er0 = !busy && v[0] && (!v[1] || pref == 0);
      er1 = !busy && v[1] && (!v[0] || pref == 1);
      rv  = busy && age >= 2;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== {er1, er0}) begin
        errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, {bus.req1_ready, bus.req0_ready}, {er1, er0});
      end
      checks++;
      if ({bus.resp1_valid, bus.resp0_valid} !== {rv && mg == 1, rv && mg == 0}) begin
        errors++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, {bus.resp1_valid, bus.resp0_valid},
                           {rv && mg == 1, rv && mg == 0});
      end
      if (rv) begin
        checks++;
        if ((mg == 0 ? {bus.resp0_data, bus.resp1_data} : {bus.resp1_data, bus.resp0_data}) !== {mres, 6'd0}) begin
          errors++; $display("FAIL rnd_data c=%0d: d0=%h d1=%h want %h on ch%0d", c, bus.resp0_data, bus.resp1_data, mres, mg);
        end
      end
      if (busy) begin
        checks++;
        if ({alu_a, alu_b, alu_op, alu_imm} !== {ma, mb, mop, mimm}) begin
          errors++; $display("FAIL rnd_alu c=%0d: got %h %h %b %h want %h %h %b %h", c, alu_a, alu_b, alu_op,
                             alu_imm, ma, mb, mop, mimm);
        end
      end
      if (busy) begin
        if (age >= 2 && (mg == 0 ? bus.resp0_ready : bus.resp1_ready)) begin
          busy = 0;
          pref = 1 - mg;
        end else begin
          age++;
        end
      end else if (er0 || er1) begin
        mg   = er1 ? 1 : 0;
        busy = 1;
        age  = 1;
        ma = ra[mg]; mb = rb[mg]; mop = rop[mg]; mimm = rimm[mg];
        mres = alu_model(ma, mb, mop, mimm);
        v[mg] = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_imm = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_imm = '0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_contention();
    test_hold();
    test_reset_mid();
    test_only_req1();
    test_random(400);
    apply_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational 6-bit ALU between two requesters (e.g. a control sequencer and a debug/test port). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers the operands onto the ALU inputs, and captures the ALU result. It holds the result until the winning requester accepts it. The ALU is instantiated beside this block, and its A/B/op/imm/Out ports connect to the alu_* ports here.

Parameters:
SIZE, 6, operand/result width; must match the ALU's SIZE
IMMW, 4, shift/rotate immediate width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
reqN_valid  in  1  (N=0,1) requester N presents an operation
reqN_ready  out  1  block accepts requester N this cycle
reqN_a, reqN_b  in  SIZE  operands
reqN_op  in  3  ALU opcode (ADD=000 SUB=001 AND=010 OR=011 SLL=100 SRL=101 SRA=110 RL=111)
reqN_imm  in  IMMW  shift/rotate amount
respN_valid  out  1  result for requester N available
respN_ready  in  1  requester N takes result
respN_data  out  SIZE  result
alu_a, alu_b  out  SIZE  to ALU A/B, registered
alu_op  out  3  to ALU op, registered
alu_imm  out  IMMW  to ALU imm, registered
alu_out  in  SIZE  from ALU Out (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high; all state clears immediately on assertion.
- Reset values: state=IDLE, pref=0 (requester 0 preferred), all reqN_ready/respN_valid=0, respN_data=0, alu_a=alu_b=0, alu_op=000, alu_imm=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, selection:
  - Only one reqN_valid is high: that requester wins.
  - Both are high: requester pref wins.
- IDLE, handshake:
  - reqN_ready=1 only for the winner, combinational from valids and pref. Both readys are 0 if no valid.
  - On valid&ready: latch a/b/op/imm into alu_* registers, record gnt=N, go to EXEC.
- EXEC (one cycle): alu_* are stable. At the clock edge, alu_out is captured into the result register, then go to RESP.
- RESP:
  - resp[gnt]_valid=1 and resp[gnt]_data=result. The other response channel stays 0.
  - Both reqN_ready are 0.
  - Data is held stable while valid.
  - On resp[gnt]_ready=1: set pref = other requester, go to IDLE.
- Latency: request accepted at edge t gives resp_valid high from t+2 (t+1 is EXEC). Respond in that cycle and the next accept is possible at t+3. Peak throughput is one op per 3 cycles.
- Continuous contention: grants strictly alternate 0,1,0,1.
- alu_* registers hold their last values outside EXEC; the ALU output is don't-care then.
- The opcode is passed through uninterpreted. Undefined behaviour belongs to the ALU (its default yields 0).
- Requester rules:
  - reqN_valid and its payload must stay stable until accepted.
  - A dropped valid before ready is a protocol violation; the bench asserts on it.
  - The block never drops a valid request.
- Reset mid-operation (EXEC or RESP): the operation is discarded with no response. After release, requester 0 is preferred.
- respN_ready high while the block is not in RESP for N: ignored.
- Back-to-back: the same requester may re-request immediately. It wins only if the other is not valid or pref points to it.

Decomposition:
- Shared package alu_pkg:
  - SIZE and IMMW defaults
  - opcode constants ADD..RL
  - state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), reused by the future sequencer
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: valid[1:0], pref, update.
  - Outputs: gnt_onehot[1:0], pref_next.
- The ALU itself stays outside. The testbench instantiates alu_arbiter plus the existing ALU.

Test Plan:
1. Reset; req0 ADD a=20 b=15 -> req0_ready same cycle; alu_a=20, alu_b=15 in EXEC; resp0_valid at accept+2 with data 35; resp1_valid stays 0.
2. After reset, both valid in the same cycle: req0 SUB a=5 b=9, req1 AND a=6'h3C b=6'h0F -> req0 served first, resp0_data=6'h3C; then req1 served, resp1_data=6'h0C.
3. Both valid continuously for 8 ops, resp readys tied high -> grant order 0,1,0,1,0,1,0,1; accepts exactly 3 cycles apart.
4. req1 RL a=6'b100001 imm=1, resp1_ready held low 5 cycles -> resp1_valid held, data 6'b000011 stable, both reqN_ready=0 throughout, no new accept; ready high -> IDLE next cycle.
5. Assert rst asynchronously mid-EXEC of req0 SRA a=6'b100100 imm=2 -> all outputs 0 immediately, no response. After release, repeat the op -> resp0_data=6'b111001.
6. Only req1 valid while pref=0 (SLL a=6'b000011 imm=3) -> req1 accepted immediately, resp1_data=6'b011000; pref becomes 0 afterwards.
